// File: rtl/dram_key_load_sequencer_if.sv
// Handshake bundle between the key/SBOX load sequencer and its neighbours
// (key source, init streamer, DRAM controller, AES engine).
interface dram_key_load_sequencer_if #(
  parameter int KEY_W = 128,
  parameter int CNT_W = 7
);
  logic             key_valid;
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_out;
  logic             init_start;
  logic             init_done;
  logic             wr_done;
  logic             aes_req;
  logic             aes_gnt;
  logic             key_ready;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output key_valid, key_in, init_done, wr_done, aes_req,
    input  key_out, init_start, aes_gnt, key_ready, busy, err, word_cnt
  );

  modport slave (
    input  key_valid, key_in, init_done, wr_done, aes_req,
    output key_out, init_start, aes_gnt, key_ready, busy, err, word_cnt
  );
endinterface

// File: rtl/dram_key_load_sequencer.sv
// Sequences loads of the DRAM key/SBOX image and arbitrates AES engine access to it.
// Optional load watchdog is compiled in with `define SEQ_WDT_EN.
module dram_key_load_sequencer #(
  parameter int KEY_W     = 128,
  parameter int NUM_WORDS = 64,
  parameter int CNT_W     = 7,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  dram_key_load_sequencer_if.slave bus
);

  if (NUM_WORDS >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for NUM_WORDS");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be positive");
  end

  typedef enum logic [2:0] {IDLE, START, LOAD, READY, ERR} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS);

  state_t           state;
  logic             pend;
  logic [KEY_W-1:0] pend_key;
  logic [KEY_W-1:0] key_out;
  logic             init_start;
  logic             aes_gnt;
  logic             key_ready;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [KEY_W-1:0] next_key;
  logic             wdt_hit;

  // A key arriving in the same cycle as a pending one is adopted supersedes it
  assign next_key = bus.key_valid ? bus.key_in : pend_key;
  assign cnt_next = word_cnt + {{(CNT_W-1){1'b0}}, bus.wr_done};

`ifdef SEQ_WDT_EN
  localparam int WDT_W = $clog2(TIMEOUT + 1);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(TIMEOUT);
  logic [WDT_W-1:0] wdt;
  assign wdt_hit = (wdt == WDT_MAX);
`else
  assign wdt_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      pend       <= 1'b0;
      pend_key   <= '0;
      key_out    <= '0;
      init_start <= 1'b0;
      aes_gnt    <= 1'b0;
      key_ready  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
`ifdef SEQ_WDT_EN
      wdt        <= '0;
`endif
    end else begin
      init_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            key_out    <= bus.key_in;
            init_start <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          word_cnt <= '0;
`ifdef SEQ_WDT_EN
          wdt      <= '0;
`endif
          if (bus.key_valid) begin
            pend     <= 1'b1;
            pend_key <= bus.key_in;
          end
          state <= LOAD;
        end
        LOAD: begin
          if (bus.key_valid) begin
            pend     <= 1'b1;
            pend_key <= bus.key_in;
          end
          if (bus.wr_done) word_cnt <= cnt_next;
`ifdef SEQ_WDT_EN
          wdt <= bus.wr_done ? '0 : wdt + WDT_W'(1);
`endif
          if (bus.wr_done && word_cnt == LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end else if (bus.init_done && cnt_next == LAST) begin
            // A key queued during the load restarts immediately, skipping READY
            if (pend || bus.key_valid) begin
              key_out    <= next_key;
              pend       <= 1'b0;
              init_start <= 1'b1;
              state      <= START;
            end else begin
              key_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= READY;
            end
          end else if (bus.init_done || wdt_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end
        end
        READY: begin
          if (!aes_gnt && (pend || (bus.key_valid && !bus.aes_req))) begin
            key_out    <= next_key;
            pend       <= 1'b0;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            init_start <= 1'b1;
            state      <= START;
          end else begin
            if (bus.key_valid) begin
              pend     <= 1'b1;
              pend_key <= bus.key_in;
            end
            // Hold an existing grant; never issue a fresh one over a stale key
            aes_gnt <= bus.aes_req && (aes_gnt || (!pend && !bus.key_valid));
          end
        end
        ERR: begin
          if (bus.key_valid || pend) begin
            key_out    <= next_key;
            pend       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
            init_start <= 1'b1;
            state      <= START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.key_out    = key_out;
  assign bus.init_start = init_start;
  assign bus.aes_gnt    = aes_gnt;
  assign bus.key_ready  = key_ready;
  assign bus.busy       = busy;
  assign bus.err        = err;
  assign bus.word_cnt   = word_cnt;

endmodule

// File: tb/tb_dram_key_load_sequencer.sv
// Directed bench for dram_key_load_sequencer: flag-based reference model compared every
// cycle, plus literal checks at the scenario milestones.
module tb_dram_key_load_sequencer;
  localparam int KW = 128;
  localparam int NW = 64;
  localparam int TO = 16;

  logic CLK, RSTn;
  int checks = 0;
  int errors = 0;

  dram_key_load_sequencer_if #(.KEY_W(KW), .CNT_W(7)) b();

  dram_key_load_sequencer #(.KEY_W(KW), .NUM_WORDS(NW), .CNT_W(7), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTn(RSTn), .bus(b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: phase flags rather than a state register
  bit          st, ld, rdy, er, pnd, m_start, m_gnt, over, stall;
  logic [KW-1:0] pk, m_key;
  int          m_cnt, idle;

  task automatic launch(input logic [KW-1:0] k);
    m_key = k; pnd = 0; st = 1; ld = 0; rdy = 0; er = 0; m_gnt = 0; m_start = 1;
  endtask

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st = 0; ld = 0; rdy = 0; er = 0; pnd = 0; m_start = 0; m_gnt = 0;
      pk = '0; m_key = '0; m_cnt = 0; idle = 0;
    end else begin
      m_start = 0;
      if (st) begin
        st = 0; ld = 1; m_cnt = 0; idle = 0;
        if (b.key_valid) begin pnd = 1; pk = b.key_in; end
      end else if (ld) begin
        over = b.wr_done && (m_cnt == NW);
`ifdef SEQ_WDT_EN
        stall = (idle >= TO);
`else
        stall = 0;
`endif
        if (b.key_valid) begin pnd = 1; pk = b.key_in; end
        if (b.wr_done) m_cnt++;
        idle = b.wr_done ? 0 : idle + 1;
        if (over) begin ld = 0; er = 1; end
        else if (b.init_done && m_cnt == NW) begin
          if (pnd) launch(pk);
          else begin ld = 0; rdy = 1; end
        end else if (b.init_done || stall) begin ld = 0; er = 1; end
      end else if (rdy) begin
        if (!m_gnt && (pnd || (b.key_valid && !b.aes_req)))
          launch(b.key_valid ? b.key_in : pk);
        else begin
          if (!b.aes_req) m_gnt = 0;
          else if (!pnd && !b.key_valid) m_gnt = 1;
          if (b.key_valid) begin pnd = 1; pk = b.key_in; end
        end
      end else if (er) begin
        if (b.key_valid) launch(b.key_in);
        else if (pnd) launch(pk);
      end else if (b.key_valid) launch(b.key_in);
    end
  end

  always @(negedge CLK) begin
    checks++;
    if ({b.key_out, b.init_start, b.aes_gnt, b.key_ready, b.busy, b.err, b.word_cnt} !==
        {m_key, m_start, m_gnt, rdy, st | ld, er, 7'(m_cnt)}) begin
      errors++;
      $display("FAIL model t=%0t got key=%h st=%b gnt=%b rdy=%b busy=%b err=%b cnt=%0d want key=%h st=%b gnt=%b rdy=%b busy=%b err=%b cnt=%0d",
        $time, b.key_out, b.init_start, b.aes_gnt, b.key_ready, b.busy, b.err, b.word_cnt,
        m_key, m_start, m_gnt, rdy, st | ld, er, m_cnt);
    end
  end

  task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic pulse_key(input logic [KW-1:0] k);
    b.key_valid = 1'b1; b.key_in = k;
    tick;
    b.key_valid = 1'b0;
  endtask

  task automatic words(input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      b.wr_done = 1'b1;
      b.init_done = done_last && (i == n - 1);
      tick;
    end
    b.wr_done = 1'b0; b.init_done = 1'b0;
  endtask

  localparam logic [KW-1:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [KW-1:0] K2 = 128'h22222222_aaaaaaaa_55555555_12345678;
  localparam logic [KW-1:0] K3 = 128'h33333333_33333333_33333333_33333333;
  localparam logic [KW-1:0] K4 = 128'h44444444_deadbeef_44444444_cafef00d;
  localparam logic [KW-1:0] K5 = 128'h55555555_00000000_55555555_00000001;
  localparam logic [KW-1:0] K6 = 128'h66666666_66666666_0123456789abcdef;
  localparam logic [KW-1:0] K7 = 128'h77777777_77777777_77777777_77777777;
  localparam logic [KW-1:0] K8 = 128'h88888888_fedcba98_76543210_88888888;

  initial begin
    #100000;
    $display("FAIL sim_timeout");
    $fatal(1);
  end

  initial begin
    RSTn = 1'b0;
    b.key_valid = 1'b0; b.key_in = '0; b.init_done = 1'b0; b.wr_done = 1'b0; b.aes_req = 1'b0;
    repeat (3) tick;
    chk("reset_key_out", b.key_out, '0);
    chk("reset_flags", {b.init_start, b.aes_gnt, b.key_ready, b.busy, b.err}, '0);
    chk("reset_word_cnt", b.word_cnt, '0);
    RSTn = 1'b1;
    tick;

    // T1 first load
    pulse_key(K1);
    chk("t1_start", b.init_start, 1);
    chk("t1_key_out", b.key_out, K1);
    tick;
    chk("t1_start_one_cycle", b.init_start, 0);
    words(64, 1);
    chk("t1_key_ready", b.key_ready, 1);
    chk("t1_word_cnt", b.word_cnt, 64);
    chk("t1_err", b.err, 0);

    // T2 grant, deferred key
    b.aes_req = 1'b1;
    tick;
    chk("t2_gnt", b.aes_gnt, 1);
    pulse_key(K2);
    chk("t2_key_held", b.key_out, K1);
    chk("t2_no_start", b.init_start, 0);
    repeat (3) tick;
    b.aes_req = 1'b0;
    tick;
    chk("t2_gnt_drop", b.aes_gnt, 0);
    tick;
    chk("t2_start", b.init_start, 1);
    chk("t2_key_out", b.key_out, K2);
    tick;

    // T3 two keys during LOAD, last wins, no READY gap
    pulse_key(K3);
    pulse_key(K4);
    words(64, 1);
    chk("t3_restart", b.init_start, 1);
    chk("t3_key_out", b.key_out, K4);
    chk("t3_no_ready", b.key_ready, 0);
    tick;
    words(64, 1);
    chk("t3_ready", b.key_ready, 1);

    // T4 early DONE, recovery, overflow
    pulse_key(K5);
    tick;
    words(10, 1);
    chk("t4_err_early", b.err, 1);
    b.aes_req = 1'b1;
    tick;
    chk("t4_no_gnt", b.aes_gnt, 0);
    b.aes_req = 1'b0;
    pulse_key(K6);
    chk("t4_err_clear", b.err, 0);
    chk("t4_restart", b.init_start, 1);
    tick;
    words(65, 0);
    chk("t4_err_overflow", b.err, 1);

    // T6 reset mid-load
    pulse_key(K7);
    tick;
    words(30, 0);
    chk("t6_word_cnt", b.word_cnt, 30);
    RSTn = 1'b0;
    #1;
    chk("t6_rst_key_out", b.key_out, '0);
    chk("t6_rst_flags", {b.init_start, b.aes_gnt, b.key_ready, b.busy, b.err, b.word_cnt}, '0);
    repeat (2) tick;
    RSTn = 1'b1;
    repeat (5) tick;
    chk("t6_idle_no_start", {b.init_start, b.busy}, '0);

    // T5 stalled load
    pulse_key(K8);
    tick;
    repeat (20) tick;
`ifdef SEQ_WDT_EN
    chk("t5_wdt_err", b.err, 1);
`else
    chk("t5_stall_busy", b.busy, 1);
    chk("t5_stall_err", b.err, 0);
`endif
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
